sram_cdc_bridge_p: RTL and testbench
====================================

SRAM_CDC_BRIDGE_P -- requirements
Module: sram_cdc_bridge_p

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width.
REQ-002 SHALL have parameter DATA_W, default 16, data width, multiple of 8; BE_W = DATA_W/8.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth, legal range 2..4.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum s_clk cycles from read issue to s_valid, range 1..65535.
REQ-005 SHALL have parameter ADDR_RETRIG, default 1; when 1, an address change under a held command issues a new access.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: s_clk in 1, rising-edge clock; s_rst_n in 1, async active-low reset.
REQ-007 SHALL have ports:
- gdp_req  in  1: GDP bus-cycle level.
- gdp_wr_req  in  1: write command, held for at least SYNC_STAGES+1 s_clk cycles.
- gdp_rd_req  in  1: read command, same hold rule.
- gdp_addr  in  ADDR_W; gdp_wdata  in  DATA_W; gdp_be  in  BE_W: byte enables.
- gdp_err_clr  in  1: clears gdp_err.
- gdp_rdata  out  DATA_W: last read data.
- gdp_ack  out  1: toggles once per completed access.
- gdp_err  out  1: sticky protocol/timeout error.
- s_req  out  1; s_wr_req, s_rd_req  out  1: one-cycle pulses.
- s_addr  out  ADDR_W; s_wdata  out  DATA_W; s_be  out  BE_W.
- s_rdata  in  DATA_W; s_valid  in  1: one-cycle read-data strobe.
- busy  out  1: FSM not IDLE or pending slot full.

Function
REQ-008 SHALL pass every gdp_* input through SYNC_STAGES flops; "synced" below means the final stage; cmd = synced wr | synced rd.
REQ-009 SHALL drive s_req as synced gdp_req delayed by one further register (latency SYNC_STAGES+1).
REQ-010 SHALL raise trigger on a rising edge of cmd, or, if ADDR_RETRIG=1, when cmd was high the previous cycle, is high now, and synced addr differs from its previous-cycle value.
REQ-011 SHALL snapshot synced addr/wdata/be/wr/rd on trigger into a command word.
REQ-012 SHALL treat synced wr and rd both high at trigger as a write and set gdp_err.
REQ-013 SHALL run FSM IDLE, ISSUE, WAIT_RD, DONE.
REQ-014 IDLE: command available (trigger or pending slot) -> ISSUE; the pending slot is served before a same-cycle trigger, and that trigger goes to the slot.
REQ-015 ISSUE (one cycle): register s_addr/s_wdata/s_be, pulse exactly one of s_wr_req/s_rd_req; write -> DONE, read -> WAIT_RD with timeout counter cleared.
REQ-016 WAIT_RD: s_valid -> capture s_rdata into gdp_rdata, -> DONE; counter reaching TIMEOUT without s_valid -> gdp_rdata = all ones, set gdp_err, -> DONE.
REQ-017 DONE (one cycle): toggle gdp_ack, -> IDLE.
REQ-018 SHALL accept a trigger in any non-IDLE state into a one-deep pending slot; a trigger with the slot full SHALL be dropped and set gdp_err.
REQ-019 SHALL ignore s_valid outside WAIT_RD; s_valid in the cycle the timeout expires SHALL win (data captured, no error).
REQ-020 SHALL hold s_addr/s_wdata/s_be stable from ISSUE until the next ISSUE.
REQ-021 Minimum latency: trigger to s_*_req pulse 1 cycle from IDLE; write trigger to ack toggle 3 cycles.
REQ-022 synced gdp_err_clr high SHALL clear gdp_err unless a set condition occurs in the same cycle; set wins.
REQ-023 busy SHALL equal (state != IDLE) | pending_valid.

Reset
REQ-024 On s_rst_n low, SHALL asynchronously clear all synchronizer stages, FSM (IDLE), pending slot, counter, s_req, s_wr_req, s_rd_req, s_addr, s_wdata, s_be, gdp_rdata, gdp_ack, gdp_err, and busy to 0.
REQ-025 Reset mid-access SHALL abandon the access with no ack toggle; the first trigger after reset release SHALL need a fresh cmd rising edge.

Verification
REQ-026 Write: addr 0x0123, wdata 0xBEEF, be 2'b11, wr held 6 cycles -> single s_wr_req pulse SYNC_STAGES+1 cycles after wr rise, s_addr 0x0123, gdp_ack toggles 2 cycles later.
REQ-027 Read: addr 0x0040, s_valid with s_rdata 0x5A5A 4 cycles after s_rd_req -> gdp_rdata 0x5A5A, ack toggles once, gdp_err 0.
REQ-028 Timeout: TIMEOUT=8, read with no s_valid -> gdp_rdata 0xFFFF, gdp_err 1 after 8 cycles; gdp_err_clr pulse -> gdp_err 0.
REQ-029 Retrigger: rd held, addr 0x0010 -> 0x0011 mid-wait -> second read queued in pending slot, two s_rd_req pulses, two ack toggles; a third change before slot drains -> dropped, gdp_err 1.
REQ-030 Simultaneous wr+rd -> write issued, gdp_err 1; s_rst_n asserted in WAIT_RD -> all outputs 0 immediately, no ack toggle.

Source files
------------

// File: rtl/sram_cdc_bridge_p.sv
// sram_cdc_bridge_p
// Carries single read/write commands from the asynchronous GDP bus domain
// into the s_clk SRAM domain. Every GDP input is synchronized, a command is
// detected on a rising edge of wr|rd (or an address change under a held
// command), and it is issued to the SRAM side as a one-cycle request pulse.
// Completion is reported back with a toggling acknowledge.
//
// Ports
//   s_clk, s_rst_n          : SRAM-side clock, async active-low reset
//   gdp_req                 : GDP bus-cycle level, forwarded as s_req
//   gdp_wr_req, gdp_rd_req  : held command levels
//   gdp_addr/wdata/be       : command payload
//   gdp_err_clr             : clears the sticky error flag
//   gdp_rdata, gdp_ack      : last read data, toggles once per access
//   gdp_err                 : sticky protocol / timeout error
//   s_req, s_wr_req, s_rd_req, s_addr, s_wdata, s_be : SRAM request side
//   s_rdata, s_valid        : SRAM read return (one-cycle strobe)
//   busy                    : access in flight or a command is queued
module sram_cdc_bridge_p #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    parameter int ADDR_RETRIG = 1
) (
    input  logic                  s_clk,
    input  logic                  s_rst_n,
    input  logic                  gdp_req,
    input  logic                  gdp_wr_req,
    input  logic                  gdp_rd_req,
    input  logic [ADDR_W-1:0]     gdp_addr,
    input  logic [DATA_W-1:0]     gdp_wdata,
    input  logic [DATA_W/8-1:0]   gdp_be,
    input  logic                  gdp_err_clr,
    output logic [DATA_W-1:0]     gdp_rdata,
    output logic                  gdp_ack,
    output logic                  gdp_err,
    output logic                  s_req,
    output logic                  s_wr_req,
    output logic                  s_rd_req,
    output logic [ADDR_W-1:0]     s_addr,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_be,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic                  s_valid,
    output logic                  busy
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

    // Synchronizer chains; index SYNC_STAGES-1 is the synced value.
    logic [SYNC_STAGES-1:0] req_sync_q, wr_sync_q, rd_sync_q, clr_sync_q;
    logic [ADDR_W-1:0]      addr_sync_q  [SYNC_STAGES];
    logic [DATA_W-1:0]      wdata_sync_q [SYNC_STAGES];
    logic [BE_W-1:0]        be_sync_q    [SYNC_STAGES];

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            req_sync_q <= '0;
            wr_sync_q  <= '0;
            rd_sync_q  <= '0;
            clr_sync_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                addr_sync_q[i]  <= '0;
                wdata_sync_q[i] <= '0;
                be_sync_q[i]    <= '0;
            end
        end else begin
            req_sync_q      <= {req_sync_q[SYNC_STAGES-2:0], gdp_req};
            wr_sync_q       <= {wr_sync_q[SYNC_STAGES-2:0], gdp_wr_req};
            rd_sync_q       <= {rd_sync_q[SYNC_STAGES-2:0], gdp_rd_req};
            clr_sync_q      <= {clr_sync_q[SYNC_STAGES-2:0], gdp_err_clr};
            addr_sync_q[0]  <= gdp_addr;
            wdata_sync_q[0] <= gdp_wdata;
            be_sync_q[0]    <= gdp_be;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                addr_sync_q[i]  <= addr_sync_q[i-1];
                wdata_sync_q[i] <= wdata_sync_q[i-1];
                be_sync_q[i]    <= be_sync_q[i-1];
            end
        end
    end

    logic              req_s, wr_s, rd_s, clr_s, cmd_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] wdata_s;
    logic [BE_W-1:0]   be_s;

    assign req_s   = req_sync_q[SYNC_STAGES-1];
    assign wr_s    = wr_sync_q[SYNC_STAGES-1];
    assign rd_s    = rd_sync_q[SYNC_STAGES-1];
    assign clr_s   = clr_sync_q[SYNC_STAGES-1];
    assign addr_s  = addr_sync_q[SYNC_STAGES-1];
    assign wdata_s = wdata_sync_q[SYNC_STAGES-1];
    assign be_s    = be_sync_q[SYNC_STAGES-1];
    assign cmd_s   = wr_s | rd_s;

    // State
    state_t            state_q;
    logic              cmd_prev_q, armed_q, cur_wr_q;
    logic [ADDR_W-1:0] addr_prev_q;
    logic [SYNC_STAGES-1:0] warm_q;
    logic              pend_v_q, pend_wr_q;
    logic [ADDR_W-1:0] pend_addr_q;
    logic [DATA_W-1:0] pend_wdata_q;
    logic [BE_W-1:0]   pend_be_q;
    logic [15:0]       cnt_q;
    logic              s_req_q, s_wr_q, s_rd_q, ack_q, err_q;
    logic [ADDR_W-1:0] s_addr_q;
    logic [DATA_W-1:0] s_wdata_q, rdata_q;
    logic [BE_W-1:0]   s_be_q;

    logic              addr_chg, trig, idle, serve_pend, load_pend, drop, timeout, err_d;
    logic              iss_wr;
    logic [ADDR_W-1:0] iss_addr;
    logic [DATA_W-1:0] iss_wdata;
    logic [BE_W-1:0]   iss_be;

    // armed_q blocks triggering until the synchronizers hold post-reset
    // values and cmd has been seen low, so a command held across reset
    // needs a fresh rising edge.
    always_comb begin
        addr_chg   = (ADDR_RETRIG != 0) && cmd_prev_q && cmd_s && (addr_s != addr_prev_q);
        trig       = armed_q && ((cmd_s && !cmd_prev_q) || addr_chg);
        idle       = (state_q == IDLE);
        serve_pend = idle && pend_v_q;
        // In IDLE the slot is drained this cycle, so a same-cycle trigger
        // refills it; elsewhere the slot only accepts when empty.
        load_pend  = trig && (idle ? pend_v_q : !pend_v_q);
        drop       = trig && !idle && pend_v_q;
        timeout    = (state_q == WAIT_RD) && !s_valid && (cnt_q == TO_LAST);
        err_d      = (trig && wr_s && rd_s) | drop | timeout | (err_q & ~clr_s);
        iss_wr     = serve_pend ? pend_wr_q    : wr_s;
        iss_addr   = serve_pend ? pend_addr_q  : addr_s;
        iss_wdata  = serve_pend ? pend_wdata_q : wdata_s;
        iss_be     = serve_pend ? pend_be_q    : be_s;
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q      <= IDLE;
            cmd_prev_q   <= 1'b0;
            armed_q      <= 1'b0;
            warm_q       <= '0;
            addr_prev_q  <= '0;
            cur_wr_q     <= 1'b0;
            pend_v_q     <= 1'b0;
            pend_wr_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            pend_be_q    <= '0;
            cnt_q        <= '0;
            s_req_q      <= 1'b0;
            s_wr_q       <= 1'b0;
            s_rd_q       <= 1'b0;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
            s_be_q       <= '0;
            rdata_q      <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            s_req_q     <= req_s;
            cmd_prev_q  <= cmd_s;
            addr_prev_q <= addr_s;
            warm_q      <= {warm_q[SYNC_STAGES-2:0], 1'b1};
            armed_q     <= armed_q | (warm_q[SYNC_STAGES-1] & ~cmd_s);
            err_q       <= err_d;
            s_wr_q      <= 1'b0;
            s_rd_q      <= 1'b0;

            if (load_pend) begin
                pend_v_q     <= 1'b1;
                pend_wr_q    <= wr_s;
                pend_addr_q  <= addr_s;
                pend_wdata_q <= wdata_s;
                pend_be_q    <= be_s;
            end else if (serve_pend) begin
                pend_v_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    // Request outputs are registered on entry to ISSUE so
                    // the pulse lands in the ISSUE cycle.
                    if (serve_pend || trig) begin
                        state_q   <= ISSUE;
                        cur_wr_q  <= iss_wr;
                        s_addr_q  <= iss_addr;
                        s_wdata_q <= iss_wdata;
                        s_be_q    <= iss_be;
                        s_wr_q    <= iss_wr;
                        s_rd_q    <= ~iss_wr;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= cur_wr_q ? DONE : WAIT_RD;
                end
                WAIT_RD: begin
                    if (s_valid) begin
                        rdata_q <= s_rdata;
                        state_q <= DONE;
                    end else if (timeout) begin
                        rdata_q <= '1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DONE: begin
                    ack_q   <= ~ack_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_req     = s_req_q;
    assign s_wr_req  = s_wr_q;
    assign s_rd_req  = s_rd_q;
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;
    assign s_be      = s_be_q;
    assign gdp_rdata = rdata_q;
    assign gdp_ack   = ack_q;
    assign gdp_err   = err_q;
    assign busy      = (state_q != IDLE) | pend_v_q;

endmodule

// File: tb/tb_sram_cdc_bridge_p.sv
// Bench for sram_cdc_bridge_p: TIMEOUT=8, other parameters default.
module tb_sram_cdc_bridge_p;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int BW = 2;

    typedef logic [35:0] acc_t; // {wr, rd, addr, wdata, be}

    logic          clk = 1'b0;
    logic          s_rst_n = 1'b0;
    logic          gdp_req = 1'b0, gdp_wr_req = 1'b0, gdp_rd_req = 1'b0, gdp_err_clr = 1'b0;
    logic [AW-1:0] gdp_addr = '0;
    logic [DW-1:0] gdp_wdata = '0;
    logic [BW-1:0] gdp_be = '0;
    logic [DW-1:0] gdp_rdata;
    logic          gdp_ack, gdp_err;
    logic          s_req, s_wr_req, s_rd_req;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [BW-1:0] s_be;
    logic [DW-1:0] s_rdata = '0;
    logic          s_valid = 1'b0;
    logic          busy;

    sram_cdc_bridge_p #(
        .ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(2), .TIMEOUT(8), .ADDR_RETRIG(1)
    ) dut (
        .s_clk(clk), .s_rst_n(s_rst_n),
        .gdp_req(gdp_req), .gdp_wr_req(gdp_wr_req), .gdp_rd_req(gdp_rd_req),
        .gdp_addr(gdp_addr), .gdp_wdata(gdp_wdata), .gdp_be(gdp_be),
        .gdp_err_clr(gdp_err_clr), .gdp_rdata(gdp_rdata), .gdp_ack(gdp_ack),
        .gdp_err(gdp_err), .s_req(s_req), .s_wr_req(s_wr_req), .s_rd_req(s_rd_req),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
        .s_rdata(s_rdata), .s_valid(s_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   ack_cnt = 0;
    logic ack_prev = 1'b0;
    acc_t exp_q[$];
    acc_t obs_q[$];

    // Monitor: records every issued SRAM access and counts ack toggles.
    always @(negedge clk) begin
        if (!s_rst_n) begin
            ack_prev = 1'b0;
        end else begin
            if (gdp_ack !== ack_prev) begin
                ack_cnt++;
                ack_prev = gdp_ack;
            end
            if (s_wr_req || s_rd_req)
                obs_q.push_back({s_wr_req, s_rd_req, s_addr, s_wdata, s_be});
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_pulse(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!(s_wr_req || s_rd_req) && lat < 40);
        if (!(s_wr_req || s_rd_req)) begin
            checks++;
            errors++;
            $display("FAIL pulse_wait: no s_wr_req/s_rd_req within %0d cycles", lat);
        end
    endtask

    task automatic wait_ack(input int base, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (ack_cnt == base && lat < 40);
        if (ack_cnt == base) begin
            checks++;
            errors++;
            $display("FAIL ack_wait: no gdp_ack toggle within %0d cycles", lat);
        end
    endtask

    task automatic sb_pop(output acc_t got, output acc_t exp, output bit ok);
        got = '1;
        exp = '0;
        ok  = (obs_q.size() > 0) && (exp_q.size() > 0);
        if (ok) begin
            got = obs_q.pop_front();
            exp = exp_q.pop_front();
        end
    endtask

    task automatic test_reset;
        s_rst_n = 1'b0;
        tick(2);
        checks++;
        if ({s_req, s_wr_req, s_rd_req, s_addr, s_wdata, s_be, gdp_rdata, gdp_ack, gdp_err, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%h rdata=%h ack=%b err=%b busy=%b, want all zero",
                     s_addr, gdp_rdata, gdp_ack, gdp_err, busy);
        end
        s_rst_n = 1'b1;
        tick(6);
        checks++;
        if (busy !== 1'b0 || gdp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b err=%b, want 0 0", busy, gdp_err);
        end
    endtask

    task automatic test_sreq;
        gdp_req = 1'b1;
        tick(2);
        checks++;
        if (s_req !== 1'b0) begin
            errors++;
            $display("FAIL s_req_early: got %b want 0", s_req);
        end
        tick();
        checks++;
        if (s_req !== 1'b1) begin
            errors++;
            $display("FAIL s_req_latency: got %b want 1", s_req);
        end
        gdp_req = 1'b0;
        tick(3);
        checks++;
        if (s_req !== 1'b0) begin
            errors++;
            $display("FAIL s_req_fall: got %b want 0", s_req);
        end
    endtask

    task automatic test_write;
        int lat, alat, base;
        acc_t got, exp;
        bit ok;
        base = ack_cnt;
        gdp_addr = 16'h0123; gdp_wdata = 16'hBEEF; gdp_be = 2'b11;
        exp_q.push_back({2'b10, 16'h0123, 16'hBEEF, 2'b11});
        gdp_wr_req = 1'b1;
        wait_pulse(lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL wr_latency: got %0d cycles want 3", lat);
        end
        wait_ack(base, alat);
        checks++;
        if (alat != 2) begin
            errors++;
            $display("FAIL wr_ack_latency: got %0d cycles want 2", alat);
        end
        tick();
        gdp_wr_req = 1'b0;
        tick(6);
        sb_pop(got, exp, ok);
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL sb_write: got %h want %h", got, exp);
        end
        checks++;
        if (obs_q.size() != 0 || ack_cnt != base + 1) begin
            errors++;
            $display("FAIL wr_single: extra accesses=%0d acks=%0d want 0 1", obs_q.size(), ack_cnt - base);
        end
        checks++;
        if (s_addr !== 16'h0123 || s_wdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL wr_hold: s_addr=%h s_wdata=%h want 0123 beef", s_addr, s_wdata);
        end
    endtask

    task automatic test_read;
        int lat, base;
        acc_t got, exp;
        bit ok;
        base = ack_cnt;
        gdp_addr = 16'h0040; gdp_wdata = 16'h0000; gdp_be = 2'b11;
        exp_q.push_back({2'b01, 16'h0040, 16'h0000, 2'b11});
        gdp_rd_req = 1'b1;
        wait_pulse(lat);
        tick(4);
        s_rdata = 16'h5A5A; s_valid = 1'b1;
        tick();
        s_valid = 1'b0; s_rdata = 16'h0000;
        checks++;
        if (gdp_rdata !== 16'h5A5A || gdp_err !== 1'b0) begin
            errors++;
            $display("FAIL rd_data: got rdata=%h err=%b want 5a5a 0", gdp_rdata, gdp_err);
        end
        wait_ack(base, lat);
        gdp_rd_req = 1'b0;
        tick(5);
        checks++;
        if (ack_cnt != base + 1) begin
            errors++;
            $display("FAIL rd_ack: got %0d toggles want 1", ack_cnt - base);
        end
        sb_pop(got, exp, ok);
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL sb_read: got %h want %h", got, exp);
        end
    endtask

    task automatic test_timeout;
        int lat, base;
        acc_t got, exp;
        bit ok;
        base = ack_cnt;
        gdp_addr = 16'h0077;
        exp_q.push_back({2'b01, 16'h0077, 16'h0000, 2'b11});
        gdp_rd_req = 1'b1;
        wait_pulse(lat);
        tick(8);
        checks++;
        if (gdp_err !== 1'b0) begin
            errors++;
            $display("FAIL to_early: err=%b want 0 at cycle 8", gdp_err);
        end
        tick();
        checks++;
        if (gdp_err !== 1'b1 || gdp_rdata !== 16'hFFFF) begin
            errors++;
            $display("FAIL to_expire: err=%b rdata=%h want 1 ffff", gdp_err, gdp_rdata);
        end
        wait_ack(base, lat);
        gdp_rd_req = 1'b0;
        tick(5);
        sb_pop(got, exp, ok);
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL sb_timeout: got %h want %h", got, exp);
        end
        gdp_err_clr = 1'b1;
        tick();
        gdp_err_clr = 1'b0;
        tick(4);
        checks++;
        if (gdp_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b want 0", gdp_err);
        end
    endtask

    task automatic test_valid_at_timeout;
        int lat, base;
        acc_t got, exp;
        bit ok;
        base = ack_cnt;
        gdp_addr = 16'h0078;
        exp_q.push_back({2'b01, 16'h0078, 16'h0000, 2'b11});
        gdp_rd_req = 1'b1;
        wait_pulse(lat);
        tick(8);
        s_rdata = 16'h1234; s_valid = 1'b1;
        tick();
        s_valid = 1'b0; s_rdata = 16'h0000;
        checks++;
        if (gdp_rdata !== 16'h1234 || gdp_err !== 1'b0) begin
            errors++;
            $display("FAIL valid_wins: rdata=%h err=%b want 1234 0", gdp_rdata, gdp_err);
        end
        wait_ack(base, lat);
        gdp_rd_req = 1'b0;
        tick(5);
        sb_pop(got, exp, ok);
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL sb_valid_wins: got %h want %h", got, exp);
        end
    endtask

    task automatic test_retrigger;
        int lat, base;
        acc_t got, exp;
        bit ok;
        base = ack_cnt;
        gdp_addr = 16'h0010;
        exp_q.push_back({2'b01, 16'h0010, 16'h0000, 2'b11});
        exp_q.push_back({2'b01, 16'h0011, 16'h0000, 2'b11});
        gdp_rd_req = 1'b1;
        wait_pulse(lat);
        tick();
        gdp_addr = 16'h0011;
        tick();
        gdp_addr = 16'h0012;
        tick(3);
        checks++;
        if (gdp_err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL retrig_drop: err=%b busy=%b want 1 1", gdp_err, busy);
        end
        s_rdata = 16'h1111; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        checks++;
        if (gdp_rdata !== 16'h1111) begin
            errors++;
            $display("FAIL retrig_first_data: rdata=%h want 1111", gdp_rdata);
        end
        wait_pulse(lat);
        tick(2);
        s_rdata = 16'h2222; s_valid = 1'b1;
        tick();
        s_valid = 1'b0; s_rdata = 16'h0000;
        checks++;
        if (gdp_rdata !== 16'h2222) begin
            errors++;
            $display("FAIL retrig_second_data: rdata=%h want 2222", gdp_rdata);
        end
        gdp_rd_req = 1'b0;
        tick(8);
        checks++;
        if (ack_cnt != base + 2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL retrig_acks: toggles=%0d busy=%b want 2 0", ack_cnt - base, busy);
        end
        for (int i = 0; i < 2; i++) begin
            sb_pop(got, exp, ok);
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL sb_retrig%0d: got %h want %h", i, got, exp);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL retrig_extra: %0d unexpected accesses want 0", obs_q.size());
        end
        gdp_err_clr = 1'b1;
        tick();
        gdp_err_clr = 1'b0;
        tick(4);
    endtask

    task automatic test_both_cmds;
        int lat, base;
        acc_t got, exp;
        bit ok;
        base = ack_cnt;
        checks++;
        if (gdp_err !== 1'b0) begin
            errors++;
            $display("FAIL both_pre: err=%b want 0", gdp_err);
        end
        gdp_addr = 16'h0200; gdp_wdata = 16'hCAFE; gdp_be = 2'b01;
        exp_q.push_back({2'b10, 16'h0200, 16'hCAFE, 2'b01});
        gdp_wr_req = 1'b1; gdp_rd_req = 1'b1;
        wait_pulse(lat);
        checks++;
        if (gdp_err !== 1'b1) begin
            errors++;
            $display("FAIL both_err: err=%b want 1", gdp_err);
        end
        wait_ack(base, lat);
        gdp_wr_req = 1'b0; gdp_rd_req = 1'b0;
        tick(5);
        sb_pop(got, exp, ok);
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL sb_both: got %h want %h", got, exp);
        end
    endtask

    task automatic test_reset_mid;
        int lat, base;
        acc_t got, exp;
        bit ok;
        gdp_addr = 16'h0300; gdp_wdata = 16'h0000; gdp_be = 2'b11;
        exp_q.push_back({2'b01, 16'h0300, 16'h0000, 2'b11});
        gdp_rd_req = 1'b1;
        wait_pulse(lat);
        tick(2);
        s_rst_n = 1'b0;
        #1;
        checks++;
        if ({s_req, s_wr_req, s_rd_req, s_addr, s_wdata, s_be, gdp_rdata, gdp_ack, gdp_err, busy} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: addr=%h ack=%b err=%b busy=%b want all zero",
                     s_addr, gdp_ack, gdp_err, busy);
        end
        base = ack_cnt;
        tick(3);
        s_rst_n = 1'b1;
        tick(10);
        checks++;
        if (obs_q.size() != 1 || ack_cnt != base || gdp_ack !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_quiet: accesses=%0d toggles=%0d ack=%b want 1 0 0",
                     obs_q.size(), ack_cnt - base, gdp_ack);
        end
        sb_pop(got, exp, ok);
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL sb_mid_reset: got %h want %h", got, exp);
        end
        gdp_rd_req = 1'b0;
        tick(3);
        exp_q.push_back({2'b01, 16'h0300, 16'h0000, 2'b11});
        gdp_rd_req = 1'b1;
        wait_pulse(lat);
        tick(2);
        s_rdata = 16'h0BAD; s_valid = 1'b1;
        tick();
        s_valid = 1'b0; s_rdata = 16'h0000;
        wait_ack(base, lat);
        gdp_rd_req = 1'b0;
        tick(5);
        checks++;
        if (gdp_rdata !== 16'h0BAD || ack_cnt != base + 1) begin
            errors++;
            $display("FAIL post_reset_read: rdata=%h toggles=%0d want 0bad 1", gdp_rdata, ack_cnt - base);
        end
        sb_pop(got, exp, ok);
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL sb_post_reset: got %h want %h", got, exp);
        end
    endtask

    initial begin
        test_reset();
        test_sreq();
        test_write();
        test_read();
        test_timeout();
        test_valid_at_timeout();
        test_retrigger();
        test_both_cmds();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
